sigrnd_arbiter: RTL
===================

// Module: sigrnd_arbiter
// PURPOSE
//  Shares one significand rounder (sigrnd) between two requesters:
//    port 0 = add/sub unit, port 1 = mul/div unit.
//  Round-robin arbitration; valid/ready handshakes on every port.
//  Two-stage pipeline: operand register -> sigrnd (combinational) -> result register.
//  Sits between the FPU execution units and the exponent-adjust / pack stage.
// PARAMETERS
//  TAG_W   4    width of opaque per-request tag, returned unchanged with the result
//  CNT_W   16   width of statistics counters (used only with SIGRND_STATS_EN)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   2       per-requester valid, bit i = port i
//  req_ready  out  2       per-requester ready (one-hot grant or 0)
//  req_s      in   2       sign, per port
//  req_db     in   2       1 = double, 0 = single, per port
//  req_f1     in   2x55    unrounded significand, per port
//  req_rm     in   2x2     rounding mode, per port
//  req_tag    in   2xTAG_W tag, per port
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_f2     out  54      rounded significand (sigrnd f2)
//  out_inx    out  1       significand inexact (sigrnd siginx)
//  out_id     out  1       index of the requester that issued the result
//  out_tag    out  TAG_W   tag of that request
// BEHAVIOUR
//  - Reset: req_ready=0, out_valid=0, out_f2/out_inx/out_id/out_tag=0.
//    Both stage valids are cleared and the RR pointer is set to last=1 (port 0 wins first).
//    A reset mid-operation discards all in-flight requests with no result.
//  - Handshake: a transfer occurs when valid & ready are both high at a rising edge.
//    Requester must hold valid and payload stable until ready; ready never depends on
//    the same port's payload.
//  - Stage 2 (result reg) loads when !s2_valid | out_ready.
//    s2_valid is cleared when out_ready=1 and stage 1 is empty.
//  - Stage 1 (operand reg) advances into stage 2 when s1_valid and stage 2 loads.
//    Stage 1 can accept a request when !s1_valid or stage 1 is advancing.
//  - Grant (combinational):
//    - Only when stage 1 can accept.
//    - Only one valid -> grant it.
//    - Both valid -> grant the port != last.
//    - last updates to the granted port on a transfer.
//  - Latency: accepted at edge N -> out_valid high after edge N+1.
//    Throughput is 1 result/cycle with out_ready held high.
//  - Backpressure: when out_ready=0 and both stages are full, req_ready=0.
//    Results are held stable; none is lost or duplicated.
//  - Simultaneous drain and accept in one cycle: allowed, no bubble.
//  - Result fields are exactly sigrnd(s,db,f1,RM) of the stage-1 operands, captured at the load edge.
//  - Ordering: results leave in grant order.
// CONFIGURATION
//  SIGRND_STATS_EN defined:
//    - Add outputs stat_ops[CNT_W-1:0] and stat_inx[CNT_W-1:0].
//    - stat_ops counts output transfers; stat_inx counts output transfers with out_inx=1.
//    - Both saturate at all-ones and reset to 0.
//  SIGRND_STATS_EN undefined: the stat ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset with port 0 valid held: req_ready=0 during rst; first cycle after rst,
//     req_ready=2'b01, out_valid=0.
//  2. Single op on port 0: s=0, db=1, f1=55'h0, rm=00, tag=4'hA, out_ready=1
//     -> out_valid 2 edges later, f2=0, inx=0, id=0, tag=A; output equals the standalone sigrnd result.
//  3. Both ports valid 4 cycles, out_ready=1 -> grants alternate 01,10,01,10;
//     out_id sequence 0,1,0,1 with no bubbles.
//  4. out_ready=0 for 5 cycles while both ports are valid -> at most 2 accepts,
//     then req_ready=0; the held result is stable; on release all results emerge in order, none lost.
//  5. Assert rst with both stages full -> out_valid=0 next cycle; the discarded tags never appear.
//  6. With SIGRND_STATS_EN: 3 ops with inexact f1 (f1=55'h7) and 2 exact ops -> stat_ops=5,
//     stat_inx=3. Force CNT_W=2 -> saturates at 3.

Source files
------------

// File: rtl/sigrnd_arbiter.sv
// sigrnd_arbiter - round-robin share of one significand rounder between add/sub (port 0) and mul/div (port 1).
// Optional SIGRND_STATS_EN adds saturating output-transfer and inexact counters.
module sigrnd_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_s,
   input  logic [1:0]            req_db,
   input  logic [1:0][54:0]      req_f1,
   input  logic [1:0][1:0]       req_rm,
   input  logic [1:0][TAG_W-1:0] req_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [53:0]           out_f2,
   output logic                  out_inx,
   output logic                  out_id,
   output logic [TAG_W-1:0]      out_tag
`ifdef SIGRND_STATS_EN
   ,
   output logic [CNT_W-1:0]      stat_ops,
   output logic [CNT_W-1:0]      stat_inx
`endif
);

   // Double keeps f1[54:2] (guard f1[1], sticky f1[0]); single keeps f1[54:31]
   // (guard f1[30], sticky |f1[29:0]) and its result is left-aligned by 29 so
   // both formats share the same MSB position in f2. Returns {inexact, f2}.
   function automatic logic [54:0] sigrnd(input logic s, input logic db,
                                          input logic [54:0] f1, input logic [1:0] rm);
      logic [52:0] kept;
      logic        g;
      logic        st;
      logic        inc;
      logic [53:0] sum;
      kept = '0;
      g    = 1'b0;
      st   = 1'b0;
      inc  = 1'b0;
      if (db) begin
         kept = f1[54:2];
         g    = f1[1];
         st   = f1[0];
      end else begin
         kept = {29'b0, f1[54:31]};
         g    = f1[30];
         st   = |f1[29:0];
      end
      case (rm)
         2'b00:   inc = g & (st | kept[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = s & (g | st);
         default: inc = ~s & (g | st);
      endcase
      sum = {1'b0, kept} + {53'b0, inc};
      if (!db)
         sum = sum << 29;
      return {g | st, sum};
   endfunction

   logic              s1_valid;
   logic              s1_s;
   logic              s1_db;
   logic [54:0]       s1_f1;
   logic [1:0]        s1_rm;
   logic [TAG_W-1:0]  s1_tag;
   logic              s1_id;
   logic              last;

   logic              s2_load;
   logic              s1_adv;
   logic              s1_open;
   logic [1:0]        grant;
   logic              xfer;
   logic              gid;
   logic [54:0]       rnd;

   always_comb begin
      s2_load = ~out_valid | out_ready;
      s1_adv  = s1_valid & s2_load;
      s1_open = ~s1_valid | s1_adv;
      grant   = 2'b00;
      if (!rst && s1_open) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
      xfer      = |grant;
      gid       = grant[1];
      req_ready = grant;
      rnd       = sigrnd(s1_s, s1_db, s1_f1, s1_rm);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_s      <= 1'b0;
         s1_db     <= 1'b0;
         s1_f1     <= '0;
         s1_rm     <= '0;
         s1_tag    <= '0;
         s1_id     <= 1'b0;
         last      <= 1'b1;
         out_valid <= 1'b0;
         out_f2    <= '0;
         out_inx   <= 1'b0;
         out_id    <= 1'b0;
         out_tag   <= '0;
      end else begin
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_f2  <= rnd[53:0];
               out_inx <= rnd[54];
               out_id  <= s1_id;
               out_tag <= s1_tag;
            end
         end
         // A new grant refills stage 1 in the same cycle it drains.
         if (xfer) begin
            s1_valid <= 1'b1;
            s1_s     <= req_s[gid];
            s1_db    <= req_db[gid];
            s1_f1    <= req_f1[gid];
            s1_rm    <= req_rm[gid];
            s1_tag   <= req_tag[gid];
            s1_id    <= gid;
            last     <= gid;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

`ifdef SIGRND_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops <= '0;
         stat_inx <= '0;
      end else if (out_valid && out_ready) begin
         if (stat_ops != {CNT_W{1'b1}})
            stat_ops <= stat_ops + 1'b1;
         if (out_inx && stat_inx != {CNT_W{1'b1}})
            stat_inx <= stat_inx + 1'b1;
      end
   end
`endif

endmodule
